// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C configuration register bank.
//   state_t  : target-side protocol FSM states
//   I2C_ACK  : SDA level for an acknowledge (pulled low)
//   I2C_NACK : SDA level for a not-acknowledge (released)
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK
    } state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_in_filter.sv
// Pad input conditioning: 2-FF synchroniser followed by a FILT-sample
// majority filter. Everything is preset to 1 (idle bus) by reset.
//   clk, rstn : clock, synchronous active-low reset
//   pad       : raw asynchronous pad input
//   filt      : synchronised, glitch-filtered level (registered)
module i2c_in_filter #(
    parameter int unsigned FILT = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic pad,
    output logic filt
);

    localparam int unsigned HW = (FILT > 1) ? FILT - 1 : 1;
    localparam int unsigned CW = $clog2(FILT + 1);

    logic          s1;
    logic          s2;
    logic [HW-1:0] hist;
    logic [FILT-1:0] taps_c;
    logic [CW-1:0] ones_c;
    logic          maj_c;

    // Window = newest synchronised sample plus FILT-1 previous ones.
    always_comb begin
        taps_c = FILT'({hist, s2});
        ones_c = '0;
        for (int unsigned i = 0; i < FILT; i++) begin
            ones_c = ones_c + CW'(taps_c[i]);
        end
        maj_c = (ones_c > CW'(FILT / 2));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            hist <= '1;
            filt <= 1'b1;
        end else begin
            s1   <= pad;
            s2   <= s1;
            hist <= HW'({hist, s2});
            filt <= maj_c;
        end
    end

endmodule

// File: rtl/i2c_cfg_regbank.sv
// I2C target configuration register bank: N_OUT R/W config bytes with
// reset defaults and N_IN read-only status bytes behind an auto-incrementing
// register pointer.
//   clk, rstn : clock (>= 16x SCL), synchronous active-low reset
//   scl_i     : raw SCL pad input
//   sda_i     : raw SDA pad input
//   sda_t     : SDA tristate control (0 = pull low, 1 = release)
//   defaults  : per-byte reset values, byte k at [8k+7:8k]
//   cfg_o     : current config bytes, same packing
//   cfg_wr    : one-cycle write strobe per config byte
//   status_i  : status bytes, same packing
//   busy      : high between START and STOP
module i2c_cfg_regbank
    import i2c_cfg_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int unsigned N_OUT    = 12,
    parameter int unsigned N_IN     = 4,
    parameter int unsigned FILT     = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_t,
    input  logic [8*N_OUT-1:0]   defaults,
    output logic [8*N_OUT-1:0]   cfg_o,
    output logic [N_OUT-1:0]     cfg_wr,
    input  logic [8*N_IN-1:0]    status_i,
    output logic                 busy
);

    localparam int unsigned TOTAL = N_OUT + N_IN;

    logic       scl_f, sda_f;
    logic       scl_q, sda_q;
    logic       scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c;
    logic       start_c, stop_c;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [6:0] rx;
    logic [7:0] tx;
    logic [6:0] ptr;
    logic       rw;
    logic       ack_drv;
    logic       mack;

    logic [7:0] byte_c;
    logic [6:0] ptr_inc_c;
    logic       ptr_in_cfg_c;
    logic [7:0] rd_byte_c;

    i2c_in_filter #(.FILT(FILT)) u_scl_filt (
        .clk  (clk),
        .rstn (rstn),
        .pad  (scl_i),
        .filt (scl_f)
    );

    i2c_in_filter #(.FILT(FILT)) u_sda_filt (
        .clk  (clk),
        .rstn (rstn),
        .pad  (sda_i),
        .filt (sda_f)
    );

    // Edge and bus-condition pulses on the filtered lines.
    assign scl_rise_c = scl_f & ~scl_q;
    assign scl_fall_c = ~scl_f & scl_q;
    assign sda_rise_c = sda_f & ~sda_q;
    assign sda_fall_c = ~sda_f & sda_q;
    assign start_c    = scl_f & sda_fall_c;
    assign stop_c     = scl_f & sda_rise_c;

    // Byte as it stands once the current SCL-rise bit is shifted in.
    assign byte_c = {rx, sda_f};

    assign ptr_inc_c    = (ptr == 7'(TOTAL - 1)) ? 7'd0 : ptr + 7'd1;
    assign ptr_in_cfg_c = ({1'b0, ptr} < 8'(N_OUT));

    // Read source: config byte, status byte, or 0xFF beyond the map.
    always_comb begin
        rd_byte_c = 8'hFF;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            if (ptr == 7'(k)) rd_byte_c = cfg_o[8*k +: 8];
        end
        for (int unsigned j = 0; j < N_IN; j++) begin
            if (ptr == 7'(N_OUT + j)) rd_byte_c = status_i[8*j +: 8];
        end
    end

    // Protocol FSM, pointer and register array. ACK states use ack_drv to
    // split into the drive phase (first SCL fall) and release phase (second).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            sda_t   <= 1'b1;
            busy    <= 1'b0;
            cfg_wr  <= '0;
            ptr     <= '0;
            cfg_o   <= defaults;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '1;
            rw      <= 1'b0;
            ack_drv <= 1'b0;
            mack    <= I2C_NACK;
        end else begin
            scl_q  <= scl_f;
            sda_q  <= sda_f;
            cfg_wr <= '0;

            if (start_c) begin
                state   <= S_ADDR;
                bit_cnt <= '0;
                busy    <= 1'b1;
                ack_drv <= 1'b0;
            end else if (stop_c) begin
                state   <= S_IDLE;
                sda_t   <= 1'b1;
                busy    <= 1'b0;
                ack_drv <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                    end

                    S_ADDR: begin
                        if (scl_rise_c) begin
                            rx      <= byte_c[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (byte_c[7:1] == DEV_ADDR) begin
                                    state   <= S_ADDR_ACK;
                                    rw      <= byte_c[0];
                                    ack_drv <= 1'b0;
                                end else begin
                                    state <= S_IDLE;
                                    sda_t <= 1'b1;
                                end
                            end
                        end
                    end

                    S_ADDR_ACK: begin
                        if (scl_fall_c) begin
                            if (!ack_drv) begin
                                sda_t   <= I2C_ACK;
                                ack_drv <= 1'b1;
                                // First read byte is fetched while the ACK is driven.
                                if (rw) begin
                                    tx  <= rd_byte_c;
                                    ptr <= ptr_inc_c;
                                end
                            end else begin
                                ack_drv <= 1'b0;
                                bit_cnt <= '0;
                                if (rw) begin
                                    state <= S_RDATA;
                                    sda_t <= tx[7];
                                end else begin
                                    state <= S_PTR;
                                    sda_t <= 1'b1;
                                end
                            end
                        end
                    end

                    S_PTR: begin
                        if (scl_rise_c) begin
                            rx      <= byte_c[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                ptr <= byte_c[6:0];
                                if (byte_c < 8'(TOTAL)) begin
                                    state   <= S_PTR_ACK;
                                    ack_drv <= 1'b0;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        end
                    end

                    S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall_c) begin
                            if (!ack_drv) begin
                                sda_t   <= I2C_ACK;
                                ack_drv <= 1'b1;
                            end else begin
                                sda_t   <= 1'b1;
                                ack_drv <= 1'b0;
                                bit_cnt <= '0;
                                state   <= S_WDATA;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (scl_rise_c) begin
                            rx      <= byte_c[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (ptr_in_cfg_c) begin
                                    for (int unsigned k = 0; k < N_OUT; k++) begin
                                        if (ptr == 7'(k)) begin
                                            cfg_o[8*k +: 8] <= byte_c;
                                            cfg_wr[k]       <= 1'b1;
                                        end
                                    end
                                    ptr     <= ptr_inc_c;
                                    state   <= S_WDATA_ACK;
                                    ack_drv <= 1'b0;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        end
                    end

                    S_RDATA: begin
                        if (scl_fall_c) begin
                            sda_t <= tx[6];
                            tx    <= {tx[6:0], 1'b1};
                        end else if (scl_rise_c) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state   <= S_RDATA_ACK;
                                ack_drv <= 1'b0;
                            end
                        end
                    end

                    S_RDATA_ACK: begin
                        if (scl_fall_c) begin
                            if (!ack_drv) begin
                                sda_t   <= 1'b1;
                                ack_drv <= 1'b1;
                            end else begin
                                ack_drv <= 1'b0;
                                if (mack == I2C_ACK) begin
                                    tx      <= rd_byte_c;
                                    sda_t   <= rd_byte_c[7];
                                    ptr     <= ptr_inc_c;
                                    bit_cnt <= '0;
                                    state   <= S_RDATA;
                                end else begin
                                    state <= S_IDLE;
                                end
                            end
                        end else if (scl_rise_c && ack_drv) begin
                            mack <= sda_f;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_regbank.sv
// Directed bench for i2c_cfg_regbank: a bit-level I2C master drives the
// pads; expected ACK bits and read bytes go through a scoreboard queue.
module tb_i2c_cfg_regbank;

    localparam int unsigned N_OUT = 12;
    localparam int unsigned N_IN  = 4;
    localparam int unsigned FILT  = 3;
    localparam int H = 16;
    localparam int Q = 8;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 scl_m, sda_m, scl_glitch;
    logic                 scl_i, sda_i;
    logic                 sda_t;
    logic [8*N_OUT-1:0]   dflt;
    logic [8*N_OUT-1:0]   cfg_o;
    logic [N_OUT-1:0]     cfg_wr;
    logic [8*N_IN-1:0]    status_i;
    logic                 busy;
    logic [8*N_OUT-1:0]   model;

    always #5 clk = ~clk;

    assign scl_i = scl_m & ~scl_glitch;
    assign sda_i = sda_m & sda_t;

    i2c_cfg_regbank #(
        .DEV_ADDR (7'h3C),
        .N_OUT    (N_OUT),
        .N_IN     (N_IN),
        .FILT     (FILT)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_t    (sda_t),
        .defaults (dflt),
        .cfg_o    (cfg_o),
        .cfg_wr   (cfg_wr),
        .status_i (status_i),
        .busy     (busy)
    );

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   wr_log[$];
    int   sda_low_cnt = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    // Strobe and SDA-drive monitors.
    always @(negedge clk) begin
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (cfg_wr[k] === 1'b1) wr_log.push_back(k);
        end
        if (sda_t === 1'b0) sda_low_cnt = sda_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_pop(input logic [7:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            check(e.tag, 96'(obs), 96'(e.val));
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b0; wclk(H);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(Q);
        scl_m = 1'b1; wclk(H);
        sda_m = 1'b1; wclk(H);
    endtask

    // Send the top n bits of b, optionally glitching SCL low for one clk.
    task automatic send_bits(input logic [7:0] b, input int n, input int glitch_bit);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wclk(Q);
            scl_m = 1'b1;
            if (i == glitch_bit) begin
                wclk(H / 2);
                scl_glitch = 1'b1; wclk(1);
                scl_glitch = 1'b0; wclk(H / 2 - 1);
            end else begin
                wclk(H);
            end
            scl_m = 1'b0; wclk(Q);
        end
    endtask

    // Full byte plus ACK clock; the ACK level goes to the scoreboard.
    task automatic send_byte(input logic [7:0] b, input int glitch_bit);
        send_bits(b, 8, glitch_bit);
        sda_m = 1'b1; wclk(Q);
        scl_m = 1'b1; wclk(H / 2);
        sb_pop(8'(sda_i));
        wclk(H / 2);
        scl_m = 1'b0; wclk(Q);
    endtask

    task automatic recv_byte(input logic nack);
        logic [7:0] b;
        b = '0;
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wclk(Q);
            scl_m = 1'b1; wclk(H / 2);
            b[i] = sda_i;
            wclk(H / 2);
            scl_m = 1'b0; wclk(Q);
        end
        sb_pop(b);
        sda_m = nack; wclk(Q);
        scl_m = 1'b1; wclk(H);
        scl_m = 1'b0; wclk(Q);
        sda_m = 1'b1;
    endtask

    initial begin
        int base;
        int lbase;

        rstn       = 1'b0;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        scl_glitch = 1'b0;
        status_i   = {8'h44, 8'h33, 8'hC3, 8'h5A};
        for (int k = 0; k < int'(N_OUT); k++) begin
            dflt[8*k +: 8] = 8'(46 - 12 * (11 - k));
        end
        model = dflt;

        // Reset defaults
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cfg_o", 96'(cfg_o), 96'(dflt));
        check("rst_sda_t", 96'(sda_t), 96'(1));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_cfg_wr", 96'(cfg_wr), 96'(0));
        rstn = 1'b1;
        wclk(10);

        // Burst write 0xAA, 0x55 at ptr 2
        base = wr_log.size();
        i2c_start();
        check("busy_after_start", 96'(busy), 96'(1));
        push("ack_addr_w", 8'h00);
        push("ack_ptr_02", 8'h00);
        push("ack_data_aa", 8'h00);
        push("ack_data_55", 8'h00);
        send_byte(8'h78, -1);
        send_byte(8'h02, -1);
        send_byte(8'hAA, -1);
        send_byte(8'h55, -1);
        i2c_stop();
        model[8*2 +: 8] = 8'hAA;
        model[8*3 +: 8] = 8'h55;
        wclk(4);
        check("busy_after_stop", 96'(busy), 96'(0));
        check("burst_cfg_o", 96'(cfg_o), 96'(model));
        check("burst_wr_count", 96'(wr_log.size() - base), 96'(2));
        if (wr_log.size() - base >= 2) begin
            check("burst_wr_first", 96'(wr_log[base]), 96'(2));
            check("burst_wr_second", 96'(wr_log[base + 1]), 96'(3));
        end

        // Read across cfg/status boundary, then continue with wrap to 0
        i2c_start();
        push("ack_addr_w", 8'h00);
        push("ack_ptr_0b", 8'h00);
        send_byte(8'h78, -1);
        send_byte(8'h0B, -1);
        i2c_start();
        push("ack_addr_r", 8'h00);
        send_byte(8'h79, -1);
        push("rd_cfg11", model[8*11 +: 8]);
        push("rd_status0", 8'h5A);
        push("rd_status1", 8'hC3);
        recv_byte(1'b0);
        recv_byte(1'b0);
        recv_byte(1'b1);
        wclk(8);
        check("sda_released_after_nack", 96'(sda_t), 96'(1));
        i2c_start();
        push("ack_addr_r2", 8'h00);
        send_byte(8'h79, -1);
        push("rd_status2", 8'h33);
        push("rd_status3", 8'h44);
        push("rd_wrap_cfg0", model[8*0 +: 8]);
        recv_byte(1'b0);
        recv_byte(1'b0);
        recv_byte(1'b1);
        i2c_stop();

        // Pointer out of range: NACK, then a read from it returns 0xFF
        i2c_start();
        push("ack_addr_w", 8'h00);
        push("nack_ptr_10", 8'h01);
        send_byte(8'h78, -1);
        send_byte(8'h10, -1);
        i2c_stop();
        i2c_start();
        push("ack_addr_r", 8'h00);
        send_byte(8'h79, -1);
        push("rd_out_of_range", 8'hFF);
        recv_byte(1'b1);
        i2c_stop();

        // Write into status space is refused
        base = wr_log.size();
        i2c_start();
        push("ack_addr_w", 8'h00);
        push("ack_ptr_0c", 8'h00);
        push("nack_wr_status", 8'h01);
        send_byte(8'h78, -1);
        send_byte(8'h0C, -1);
        send_byte(8'h99, -1);
        i2c_stop();
        wclk(4);
        check("status_wr_count", 96'(wr_log.size() - base), 96'(0));
        check("status_wr_cfg_o", 96'(cfg_o), 96'(model));

        // Wrong device address
        lbase = sda_low_cnt;
        i2c_start();
        push("nack_addr_40", 8'h01);
        send_byte(8'h80, -1);
        i2c_stop();
        wclk(4);
        check("wrong_addr_sda_low_cycles", 96'(sda_low_cnt - lbase), 96'(0));
        check("wrong_addr_busy", 96'(busy), 96'(0));

        // STOP in the middle of a data byte discards it
        base = wr_log.size();
        i2c_start();
        push("ack_addr_w", 8'h00);
        push("ack_ptr_06", 8'h00);
        send_byte(8'h78, -1);
        send_byte(8'h06, -1);
        send_bits(8'h5A, 4, -1);
        i2c_stop();
        wclk(4);
        check("partial_wr_count", 96'(wr_log.size() - base), 96'(0));
        check("partial_cfg_o", 96'(cfg_o), 96'(model));

        // SCL glitch during a valid write is filtered out
        base = wr_log.size();
        i2c_start();
        push("ack_addr_w", 8'h00);
        push("ack_ptr_05", 8'h00);
        push("ack_data_3c", 8'h00);
        send_byte(8'h78, -1);
        send_byte(8'h05, -1);
        send_byte(8'h3C, 4);
        i2c_stop();
        model[8*5 +: 8] = 8'h3C;
        wclk(4);
        check("glitch_cfg_o", 96'(cfg_o), 96'(model));
        check("glitch_wr_count", 96'(wr_log.size() - base), 96'(1));
        if (wr_log.size() - base >= 1) begin
            check("glitch_wr_index", 96'(wr_log[base]), 96'(5));
        end

        // Reset in the middle of a data byte
        base = wr_log.size();
        i2c_start();
        push("ack_addr_w", 8'h00);
        push("ack_ptr_04", 8'h00);
        send_byte(8'h78, -1);
        send_byte(8'h04, -1);
        send_bits(8'h81, 4, -1);
        rstn = 1'b0;
        wclk(2);
        check("abort_busy", 96'(busy), 96'(0));
        check("abort_sda_t", 96'(sda_t), 96'(1));
        check("abort_cfg_o", 96'(cfg_o), 96'(dflt));
        check("abort_wr_count", 96'(wr_log.size() - base), 96'(0));
        rstn  = 1'b1;
        scl_m = 1'b1; wclk(Q);
        sda_m = 1'b1; wclk(H);
        model = dflt;

        // Fresh write after the abort
        base = wr_log.size();
        i2c_start();
        push("ack_addr_w", 8'h00);
        push("ack_ptr_01", 8'h00);
        push("ack_data_77", 8'h00);
        send_byte(8'h78, -1);
        send_byte(8'h01, -1);
        send_byte(8'h77, -1);
        i2c_stop();
        model[8*1 +: 8] = 8'h77;
        wclk(4);
        check("post_abort_cfg_o", 96'(cfg_o), 96'(model));
        check("post_abort_wr_count", 96'(wr_log.size() - base), 96'(1));

        check("scoreboard_drained", 96'(sb.size()), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_regbank.md
# i2c_cfg_regbank

Parametrised I2C-target configuration register bank for the chip-level system controller. It is clocked from the 25 MHz reference domain and exposes `N_OUT` writable configuration bytes with per-register reset defaults, plus `N_IN` read-only status bytes. It generalises the fixed-size controller with:

- a configurable 7-bit device address;
- SCL/SDA input synchronisation and glitch filtering;
- a register pointer with auto-increment;
- range-checked NACK;
- one-cycle write strobes per register.

## Interface

Parameters:
- `DEV_ADDR`, 7'h3C — 7-bit target address.
- `N_OUT`, 12 — number of R/W config bytes, 1..127.
- `N_IN`, 4 — number of read-only status bytes, 0..128-`N_OUT`.
- `FILT`, 3 — glitch-filter length in clk samples, odd, 1..7.

Ports:
- `clk` in 1 — only clock; must be ≥ 16× SCL frequency.
- `rstn` in 1 — synchronous, active-low reset.
- `scl_i` in 1 — raw SCL pad input (asynchronous).
- `sda_i` in 1 — raw SDA pad input (asynchronous).
- `sda_t` out 1 — SDA tristate: 0 = pull low, 1 = release. The pad output is tied to 0.
- `defaults` in 8*`N_OUT` — reset value of each config byte; byte k is at [8k+7:8k]. Sampled only during reset.
- `cfg_o` out 8*`N_OUT` — current config bytes, same packing.
- `cfg_wr` out `N_OUT` — one-cycle pulse when byte k is written.
- `status_i` in 8*`N_IN` — status bytes, same packing.
- `busy` out 1 — high between a START and the following STOP.

## Operation

Input conditioning:
- `scl_i` and `sda_i` each pass through a 2-FF synchroniser and then a `FILT`-deep majority filter. Everything below uses the filtered values.
- Edge detects are one-cycle pulses derived from the filtered signals.

Bus conditions:
- **START**: SDA falls while SCL is high. Valid in any state, including repeated START.
  - Goes to ADDR, clears the bit counter, sets `busy`.
- **STOP**: SDA rises while SCL is high.
  - Goes to IDLE, releases SDA, clears `busy`.

FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.

- **Bit handling**: data bits are sampled on the SCL rising edge, MSB first. The bit counter runs 0..7; count 7 completes a byte.
- **ADDR**:
  - Address matches `DEV_ADDR`: ACK, then go to PTR on a write or RDATA on a read.
  - No match: release SDA and go to IDLE, ignoring the bus until the next START.
- **PTR**: the received byte is loaded into the pointer `ptr` (7-bit).
  - ACK if `ptr` < `N_OUT`+`N_IN`, else NACK and go to IDLE.
- **WDATA**:
  - If `ptr` < `N_OUT`: write the byte to cfg[`ptr`], pulse `cfg_wr[ptr]` in the cycle the byte completes, ACK, then increment `ptr`.
  - Otherwise (including status indices): NACK, no write, go to IDLE.
- **RDATA**:
  - The shift register loads when the read byte starts: on the address ACK, or on the SCL falling edge after the master's ACK.
  - Load value: cfg[`ptr`], or status[`ptr`-`N_OUT`], or 8'hFF when out of range.
  - `status_i` is sampled at that load cycle only.
  - `ptr` increments after the load.
- **RDATA_ACK**:
  - Master ACK (SDA low): go to the next RDATA.
  - Master NACK: release SDA, go to IDLE.
- **Pointer wrap**: `ptr` wraps to 0 after index `N_OUT`+`N_IN`-1. `ptr` keeps its value across transactions, so a repeated-START read continues from the last pointer.

## Timing

Reset values (`rstn`=0 at a clk edge):
- FSM = IDLE, `sda_t`=1, `busy`=0, `cfg_wr`=0, `ptr`=0, `cfg_o`=`defaults`.
- Filters and synchronisers preset to 1 (idle bus).
- Reset during a transfer abandons it with no write and no strobe.

Latency:
- 2 (sync) + (`FILT`+1)/2 (filter) cycles from pad to internal edge.

SDA drive rules:
- `sda_t` changes only in the cycle after a filtered SCL falling edge, never while SCL is high.
- ACK/data is held through the full SCL high phase and released on the next SCL falling edge.

Write timing:
- `cfg_o` updates and `cfg_wr` pulses in the same cycle, on the SCL rise of bit 0 (the 8th bit).
- A START or STOP arriving mid-byte discards the partial byte: no write.

## Structure

- Package `i2c_cfg_pkg`:
  - `typedef enum` for the FSM states.
  - localparams `I2C_ACK`=0 and `I2C_NACK`=1.
- Sub-module `i2c_in_filter`: 2-FF synchroniser + majority filter, parameter `FILT`. Instantiated twice, for SCL and SDA.
- The FSM, pointer and register array live in the top module.

## Test plan

- **Reset defaults**: `defaults`={8'd46,8'd34,…}, hold `rstn` low for 2 cycles → `cfg_o` equals `defaults`, `sda_t`=1, `busy`=0.
- **Burst write**: START, 0x78 (0x3C+W), ptr 0x02, data 0xAA, 0x55, STOP →
  - ACK on all bytes;
  - cfg[2]=0xAA and cfg[3]=0x55;
  - `cfg_wr[2]` then `cfg_wr[3]` each high for exactly 1 cycle.
- **Read across the cfg/status boundary**: with `N_OUT`=12, `status_i` byte0=0x5A:
  - write ptr 0x0B, repeated START, 0x79, read 3 bytes with ACK, ACK, NACK;
  - → returns cfg[11], 0x5A, status[1];
  - `sda_t` released after the NACK.
- **Range checks**:
  - ptr 0x10 (= `N_OUT`+`N_IN`) → NACK on the pointer byte;
  - write to ptr 0x0C (status) → NACK, `cfg_wr`=0.
- **Wrong address and glitches**:
  - address 0x40 → no ACK, `sda_t` stays 1;
  - a 1-cycle SCL glitch during a valid write → filtered out, data correct.
- **Abort**: `rstn` low mid-data byte → FSM IDLE, no `cfg_wr`, `cfg_o`=`defaults`.
